brick_render: RTL
=================

Name: brick_render

Overview:
- Read-side consumer of the 24-bit brick occupancy map (3 rows x 8 columns, bit index row*8+col, 1 = brick present) maintained by the ball/brick collision logic.
- Takes VGA scan coordinates and produces a pipelined brick pixel colour for the video mux.
- Snapshots the map once per frame, counts the remaining bricks, and runs a level-clear flash sequence when the count reaches zero.

Parameters:
- X0, 64, left edge of brick field in pixels; field spans X0..X0+511, 64 px per column.
- Y0, 64, top edge of brick field in scan lines from top of screen; field spans Y0..Y0+95, 32 lines per row.
- FLASH_FRAMES, 60, number of frames spent in FLASH state (max 255).
- BLINK_SHIFT, 3, flash toggles every 2^BLINK_SHIFT frames.
- ROW0_RGB / ROW1_RGB / ROW2_RGB, 8'hE0 / 8'hFC / 8'h1C, RGB332 colour per brick row (row 0 = top).

Ports:
- clk  input  1  pixel clock.
- rst  input  1  asynchronous, active-low reset.
- arr_in  input  24  live brick map from collision block.
- h_cnt  input  11  current pixel x (0 = left).
- v_cnt  input  11  current scan line y (0 = top).
- video_on  input  1  high in visible area.
- frame_start  input  1  one-cycle pulse at start of vertical blanking.
- brick_pix  output  1  current (delayed) pixel is a drawn brick.
- rgb_out  output  8  RGB332 brick colour, 0 when brick_pix low.
- brick_count  output  5  bricks remaining in current snapshot, 0..24.
- level_clear  output  1  one-cycle pulse on FLASH->DONE.
- flashing  output  1  high while in FLASH.

Behaviour:
- Reset (rst=0, async): snapshot=24'hFFFFFF, brick_count=24, state=PLAY, frame counter=0, brick_pix=0, rgb_out=0, level_clear=0, flashing=0; all pipeline valid bits cleared.
- Snapshot: on a cycle with frame_start=1, snapshot<=arr_in. brick_count<=popcount(arr_in) on the same edge. Mid-frame changes to arr_in never affect the drawn frame.
- Pixel pipeline, latency 2 cycles from (h_cnt, v_cnt, video_on) to (brick_pix, rgb_out).
  - Stage 1 registers: in_field = video_on && X0<=h_cnt<X0+512 && Y0<=v_cnt<Y0+96; col=(h_cnt-X0)>>6 (3 bits); row=(v_cnt-Y0)>>5 (2 bits); mortar flag. Subtractions use 11-bit unsigned, guarded by the range compare.
  - Stage 2: brick_pix = in_field && snapshot[row*8+col] && !mortar && !blank; rgb_out = row colour if brick_pix, else 0.
  - row==3 is impossible by the range check; h_cnt/v_cnt outside range always give 0.
- FSM, evaluated only on frame_start edges:
  - PLAY -> FLASH when popcount(arr_in)==0. Frame counter is cleared on entry.
  - FLASH: counter increments every frame_start. blank = counter[BLINK_SHIFT], with the field drawn as if all 24 bits are set (full field blinks). When counter==FLASH_FRAMES-1, go to DONE and pulse level_clear for exactly one clock.
  - DONE: nothing drawn. Go to PLAY when popcount(arr_in)!=0, i.e. the map is reloaded.
  - If the map becomes nonzero during FLASH, return to PLAY on that frame_start with no level_clear.
- flashing = (state==FLASH), registered.
- Reset asserted mid-frame or mid-flash returns immediately to the reset values. Drawing resumes from the first frame_start after release; until then the snapshot is all ones.

Optional Feature:
- BRICK_BORDER_EN defined: mortar = ((h_cnt-X0)[5:0]==0) || ((v_cnt-Y0)[4:0]==0). This gives a 1-pixel gap on the left and top of each brick.
- Undefined: mortar is constant 0, so bricks tile solidly. Latency and all other behaviour are unchanged.

Test Plan:
- Reset then frame_start with arr_in=24'hFFFFFF; pixel (100,70) -> two cycles later brick_pix=1, rgb_out=8'hE0; brick_count=24.
- arr_in=24'h000100 (row1 col0) after frame_start; (80,100) -> rgb_out=8'hFC; (150,100) -> 0; (600,100) and (100,200) -> 0.
- Change arr_in mid-frame from 24'hFFFFFF to 0 -> drawn output unchanged until next frame_start; brick_count then 0 and flashing=1.
- With arr_in=0 held and FLASH_FRAMES=60 -> brick field toggles every 8 frames; level_clear is a single-cycle pulse after the 60th frame_start; then DONE with no output. Load arr_in=24'hFFFFFF -> PLAY on next frame_start.
- With BRICK_BORDER_EN, arr_in all ones: (64,70) -> 0, (65,70) -> 1, (100,96) -> 0. Without the macro, all three give 1.
- Assert rst during FLASH -> flashing=0, brick_count=24, brick_pix=0 immediately (asynchronous), with no level_clear pulse.

Source files
------------

// File: rtl/brick_render.sv
// Brick field renderer: per-frame map snapshot, brick count, level-clear flash sequencer. Optional macro: BRICK_BORDER_EN.
// Latency: 2 clk from (h_cnt, v_cnt, video_on) to (brick_pix, rgb_out); map/state update on frame_start edges.
// Backpressure: none, free-running pixel stream.
module brick_render #(
    parameter int          X0           = 64,
    parameter int          Y0           = 64,
    parameter int          FLASH_FRAMES = 60,
    parameter int          BLINK_SHIFT  = 3,
    parameter logic [7:0]  ROW0_RGB     = 8'hE0,
    parameter logic [7:0]  ROW1_RGB     = 8'hFC,
    parameter logic [7:0]  ROW2_RGB     = 8'h1C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] arr_in,
    input  logic [10:0] h_cnt,
    input  logic [10:0] v_cnt,
    input  logic        video_on,
    input  logic        frame_start,
    output logic        brick_pix,
    output logic [7:0]  rgb_out,
    output logic [4:0]  brick_count,
    output logic        level_clear,
    output logic        flashing
);

    typedef enum logic [1:0] {PLAY, FLASH, DONE} state_t;

    localparam logic [10:0] X_LO       = 11'(X0);
    localparam logic [10:0] X_HI       = 11'(X0 + 512);
    localparam logic [10:0] Y_LO       = 11'(Y0);
    localparam logic [10:0] Y_HI       = 11'(Y0 + 96);
    localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);

    function automatic logic [4:0] popcount(input logic [23:0] m);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 24; i++) c = c + 5'(m[i]);
        return c;
    endfunction

    state_t      state, state_nxt;
    logic [7:0]  frame_cnt, frame_cnt_nxt;
    logic        clr_nxt;
    logic [23:0] snapshot;
    logic [4:0]  arr_pop;
    logic        arr_zero;

    assign arr_pop  = popcount(arr_in);
    assign arr_zero = (arr_pop == 5'd0);

    // Sequencer only advances on frame_start so each decision sees a whole frame.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        clr_nxt       = 1'b0;
        if (frame_start) begin
            case (state)
                PLAY: begin
                    if (arr_zero) begin
                        state_nxt     = FLASH;
                        frame_cnt_nxt = '0;
                    end
                end
                FLASH: begin
                    if (!arr_zero) begin
                        state_nxt = PLAY;
                    end else if (frame_cnt == FLASH_LAST) begin
                        state_nxt = DONE;
                        clr_nxt   = 1'b1;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (!arr_zero) state_nxt = PLAY;
                end
                default: state_nxt = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= PLAY;
            frame_cnt   <= '0;
            level_clear <= 1'b0;
            flashing    <= 1'b0;
            snapshot    <= 24'hFFFFFF;
            brick_count <= 5'd24;
        end else begin
            state       <= state_nxt;
            frame_cnt   <= frame_cnt_nxt;
            level_clear <= clr_nxt;
            flashing    <= (state_nxt == FLASH);
            if (frame_start) begin
                snapshot    <= arr_in;
                brick_count <= arr_pop;
            end
        end
    end

    // Stage 1: field decode
    logic       s1_in_field, s1_mortar;
    logic [2:0] s1_col;
    logic [1:0] s1_row;
    logic       in_rng, mortar_d;

    assign in_rng = video_on && (h_cnt >= X_LO) && (h_cnt < X_HI)
                             && (v_cnt >= Y_LO) && (v_cnt < Y_HI);

`ifdef BRICK_BORDER_EN
    assign mortar_d = (6'(h_cnt - X_LO) == 6'd0) || (5'(v_cnt - Y_LO) == 5'd0);
`else
    assign mortar_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_in_field <= 1'b0;
            s1_mortar   <= 1'b0;
            s1_col      <= '0;
            s1_row      <= '0;
        end else begin
            s1_in_field <= in_rng;
            s1_mortar   <= mortar_d;
            s1_col      <= 3'((h_cnt - X_LO) >> 6);
            s1_row      <= 2'((v_cnt - Y_LO) >> 5);
        end
    end

    // Stage 2: map lookup; the whole field is lit during the flash sequence
    logic [23:0] draw_map;
    logic        blank, pix_d;
    logic [7:0]  row_rgb;

    assign draw_map = (state == FLASH) ? 24'hFFFFFF : snapshot;
    assign blank    = ((state == FLASH) && frame_cnt[BLINK_SHIFT]) || (state == DONE);
    assign pix_d    = s1_in_field && draw_map[{s1_row, s1_col}] && !s1_mortar && !blank;

    always_comb begin
        case (s1_row)
            2'd0:    row_rgb = ROW0_RGB;
            2'd1:    row_rgb = ROW1_RGB;
            default: row_rgb = ROW2_RGB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brick_pix <= 1'b0;
            rgb_out   <= '0;
        end else begin
            brick_pix <= pix_d;
            rgb_out   <= pix_d ? row_rgb : 8'h00;
        end
    end

endmodule
